// File: rtl/bl_dpram_be.sv
// True dual-port byte-enabled RAM with post-reset zero-fill sequencer.
// Latency: READ_LAT (1 or 2) cycles from accepted request to rdata/rvalid.
// Backpressure: requests are ignored while ready=0 (reset and clear phase).
module bl_dpram_be #(
  parameter int DATA_W         = 32,
  parameter int WORDS          = 256,
  parameter int ADDR_W         = 22,
  parameter int READ_LAT       = 1,
  parameter int WR_FIRST       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              a_req,
  input  logic [NB-1:0]     a_wen,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic [NB-1:0]     b_wen,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  // Range check is done on the full address so nothing above WORDS aliases.
  localparam logic [ADDR_W:0]  WORDS_V = (ADDR_W + 1)'(WORDS);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [WORDS];

  logic              a_acc, a_in, b_acc, b_in;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic [DATA_W-1:0] a_rd, b_rd;
  logic              a_p_vld, b_p_vld;
  logic [DATA_W-1:0] a_p_dat, b_p_dat;

  assign a_acc = a_req & ready;
  assign b_acc = b_req & ready;
  assign a_in  = ({1'b0, a_addr} < WORDS_V);
  assign b_in  = ({1'b0, b_addr} < WORDS_V);
  assign a_idx = a_addr[IDX_W-1:0];
  assign b_idx = b_addr[IDX_W-1:0];

  // Read word per port: pre-write contents, optionally merged with own write lanes.
  always_comb begin
    a_rd = '0;
    b_rd = '0;
    if (a_in) begin
      a_rd = mem[a_idx];
      if (WR_FIRST != 0) begin
        for (int i = 0; i < NB; i++) begin
          if (a_wen[i]) a_rd[8*i +: 8] = a_wdata[8*i +: 8];
        end
      end
    end
    if (b_in) begin
      b_rd = mem[b_idx];
      if (WR_FIRST != 0) begin
        for (int i = 0; i < NB; i++) begin
          if (b_wen[i]) b_rd[8*i +: 8] = b_wdata[8*i +: 8];
        end
      end
    end
  end

  // Array update: clear fill, then B lanes, then A lanes so A wins on overlap.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) mem[cnt] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (b_acc && b_in && b_wen[i]) mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
    end
    for (int i = 0; i < NB; i++) begin
      if (a_acc && a_in && a_wen[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  // Clear sequencer: RESET -> (CLEAR) -> RUN, ready registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          cnt <= '0;
          if (CLEAR_ON_RESET != 0) begin
            state <= S_CLEAR;
          end else begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= S_RUN;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Read pipeline for both ports; rdata only moves when a valid lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p_vld  <= 1'b0;
      a_p_dat  <= '0;
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_p_vld  <= 1'b0;
      b_p_dat  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_p_vld <= a_acc;
      b_p_vld <= b_acc;
      if (a_acc) a_p_dat <= a_rd;
      if (b_acc) b_p_dat <= b_rd;
      if (READ_LAT == 2) begin
        a_rvalid <= a_p_vld;
        b_rvalid <= b_p_vld;
        if (a_p_vld) a_rdata <= a_p_dat;
        if (b_p_vld) b_rdata <= b_p_dat;
      end else begin
        a_rvalid <= a_acc;
        b_rvalid <= b_acc;
        if (a_acc) a_rdata <= a_rd;
        if (b_acc) b_rdata <= b_rd;
      end
    end
  end

endmodule

// File: tb/tb_bl_dpram_be.sv
// Directed bench: two instances share stimulus.
// l1: READ_LAT=1, WR_FIRST=0.  l2: READ_LAT=2, WR_FIRST=1.  Both WORDS=16.
module tb_bl_dpram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, b_req;
  logic [3:0]  a_wen, b_wen;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic        l1_ready, l1_a_rvalid, l1_b_rvalid;
  logic [31:0] l1_a_rdata, l1_b_rdata;
  logic        l2_ready, l2_a_rvalid, l2_b_rvalid;
  logic [31:0] l2_a_rdata, l2_b_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bl_dpram_be #(.DATA_W(32), .WORDS(16), .ADDR_W(8), .READ_LAT(1), .WR_FIRST(0),
                .CLEAR_ON_RESET(1)) u_l1 (
    .clk(clk), .rst(rst), .ready(l1_ready),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(l1_a_rdata), .a_rvalid(l1_a_rvalid),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(l1_b_rdata), .b_rvalid(l1_b_rvalid)
  );

  bl_dpram_be #(.DATA_W(32), .WORDS(16), .ADDR_W(8), .READ_LAT(2), .WR_FIRST(1),
                .CLEAR_ON_RESET(1)) u_l2 (
    .clk(clk), .rst(rst), .ready(l2_ready),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(l2_a_rdata), .a_rvalid(l2_a_rvalid),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(l2_b_rdata), .b_rvalid(l2_b_rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One request on each enabled port; checks l1 after one edge and l2 after two.
  task automatic xfer(input string tag,
                      input logic ae, input logic [3:0] aw, input logic [7:0] aa,
                      input logic [31:0] ad, input logic [31:0] ea1, input logic [31:0] ea2,
                      input logic be, input logic [3:0] bw, input logic [7:0] ba,
                      input logic [31:0] bd, input logic [31:0] eb1, input logic [31:0] eb2);
    a_req = ae; a_wen = aw; a_addr = aa; a_wdata = ad;
    b_req = be; b_wen = bw; b_addr = ba; b_wdata = bd;
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    chk({tag, ":l1_av"}, 32'(l1_a_rvalid), 32'(ae));
    chk({tag, ":l1_bv"}, 32'(l1_b_rvalid), 32'(be));
    chk({tag, ":l2_av_early"}, 32'(l2_a_rvalid), 32'd0);
    if (ae) chk({tag, ":l1_ad"}, l1_a_rdata, ea1);
    if (be) chk({tag, ":l1_bd"}, l1_b_rdata, eb1);
    @(posedge clk); #1;
    chk({tag, ":l2_av"}, 32'(l2_a_rvalid), 32'(ae));
    chk({tag, ":l2_bv"}, 32'(l2_b_rvalid), 32'(be));
    chk({tag, ":l1_av_end"}, 32'(l1_a_rvalid), 32'd0);
    if (ae) chk({tag, ":l2_ad"}, l2_a_rdata, ea2);
    if (be) chk({tag, ":l2_bd"}, l2_b_rdata, eb2);
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] e);
    xfer(tag, 1'b1, 4'h0, addr, 32'h0, e, e, 1'b0, 4'h0, 8'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Called with rst just released: one edge leaves RESET, then count CLEAR cycles.
  task automatic wait_ready(input string tag);
    int n;
    logic rv;
    n = 0;
    rv = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":rdy_lo"}, 32'(l1_ready), 32'd0);
    while (!l1_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (l1_a_rvalid || l2_a_rvalid) rv = 1'b1;
    end
    chk({tag, ":cycles"}, 32'(n), 32'd16);
    chk({tag, ":l2_rdy"}, 32'(l2_ready), 32'd1);
    chk({tag, ":no_rv"}, 32'(rv), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_wen = '0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wen = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:ready", {l2_ready, l1_ready}, 32'd0);
    chk("rst:rv", {l2_b_rvalid, l2_a_rvalid, l1_b_rvalid, l1_a_rvalid}, 32'd0);
    chk("rst:l1_ad", l1_a_rdata, 32'h0);
    chk("rst:l2_bd", l2_b_rdata, 32'h0);

    // Held write request during clear must be ignored.
    a_req = 1'b1; a_wen = 4'hF; a_addr = 8'd0; a_wdata = 32'hDEADBEEF;
    rst = 1'b0;
    wait_ready("clr");
    a_req = 1'b0;
    for (int i = 0; i < 16; i++) rd($sformatf("zero%0d", i), 8'(i), 32'h0);

    // Byte lanes, read-during-write on the same port.
    xfer("w3a", 1'b1, 4'hF, 8'd3, 32'hAABBCCDD, 32'h0, 32'hAABBCCDD,
         1'b0, 4'h0, 8'h0, 32'h0, 32'h0, 32'h0);
    xfer("w3b", 1'b1, 4'h5, 8'd3, 32'h11223344, 32'hAABBCCDD, 32'hAA22CC44,
         1'b0, 4'h0, 8'h0, 32'h0, 32'h0, 32'h0);
    rd("r3", 8'd3, 32'hAA22CC44);
    xfer("w5", 1'b1, 4'h3, 8'd5, 32'hFFFFFFFF, 32'h0, 32'h0000FFFF,
         1'b0, 4'h0, 8'h0, 32'h0, 32'h0, 32'h0);
    rd("r5", 8'd5, 32'h0000FFFF);

    // Back-to-back reads, one per cycle.
    a_req = 1'b1; a_wen = 4'h0; a_addr = 8'd3;
    @(posedge clk); #1;
    chk("pipe:l1_d0", l1_a_rdata, 32'hAA22CC44);
    a_addr = 8'd5;
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("pipe:l1_d1", l1_a_rdata, 32'h0000FFFF);
    chk("pipe:l2_d0", l2_a_rdata, 32'hAA22CC44);
    chk("pipe:l2_v0", 32'(l2_a_rvalid), 32'd1);
    @(posedge clk); #1;
    chk("pipe:l2_d1", l2_a_rdata, 32'h0000FFFF);
    chk("pipe:l2_v1", 32'(l2_a_rvalid), 32'd1);
    chk("pipe:l1_v2", 32'(l1_a_rvalid), 32'd0);
    @(posedge clk); #1;
    chk("pipe:l2_hold", l2_a_rdata, 32'h0000FFFF);

    // Both ports write the same word in the same cycle; A wins shared lanes.
    a_req = 1'b1; a_wen = 4'hC; a_addr = 8'd7; a_wdata = 32'h12345678;
    b_req = 1'b1; b_wen = 4'h6; b_addr = 8'd7; b_wdata = 32'h9ABCDEF0;
    @(posedge clk); #1;
    a_addr = 8'd8; b_addr = 8'd8; b_wen = 4'h7;
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd("col7", 8'd7, 32'h1234DE00);
    rd("col8", 8'd8, 32'h1234DEF0);

    // A writes while B reads the same word: B sees pre-write data in both modes.
    xfer("xrw", 1'b1, 4'hF, 8'd9, 32'h55667788, 32'h0, 32'h55667788,
         1'b1, 4'h0, 8'd9, 32'h0, 32'h0, 32'h0);
    xfer("b9", 1'b0, 4'h0, 8'h0, 32'h0, 32'h0, 32'h0,
         1'b1, 4'h0, 8'd9, 32'h0, 32'h55667788, 32'h55667788);

    // Out of range: write dropped, read zero, no alias onto word 0.
    xfer("oor_w", 1'b1, 4'hF, 8'd16, 32'hDEADBEEF, 32'h0, 32'h0,
         1'b0, 4'h0, 8'h0, 32'h0, 32'h0, 32'h0);
    rd("oor_r", 8'd16, 32'h0);
    rd("oor_a0", 8'd0, 32'h0);

    // Reset with an l2 read in flight.
    a_req = 1'b1; a_wen = 4'h0; a_addr = 8'd3;
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("rflt:l1_d", l1_a_rdata, 32'hAA22CC44);
    rst = 1'b1;
    #1;
    chk("rflt:l2_v", 32'(l2_a_rvalid), 32'd0);
    chk("rflt:l2_d", l2_a_rdata, 32'h0);
    chk("rflt:l1_d0", l1_a_rdata, 32'h0);
    chk("rflt:ready", {l2_ready, l1_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rflt:l2_v2", 32'(l2_a_rvalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Interrupt the clear at count 7, then a full restart is expected.
    @(posedge clk); #1;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("clr_mid");
    rd("post_r3", 8'd3, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
